seq_borrow_sub: RTL and testbench
=================================

Name: seq_borrow_sub

Overview:
- Multi-cycle WIDTH-bit subtractor computing Diff = A - B - Bin, one SLICE-bit borrow-lookahead slice per clock, LSB slice first.
- Inverse-direction companion to the arithmetic library's combinational carry-lookahead adder.
- Used where a wide subtract must meet timing with a small slice: ALU datapaths, comparators, divider remainder steps.
- Valid/ready handshake on both input and output; one operation in flight at a time.

Parameters:
- WIDTH, 32, operand/result width; must be an integer multiple of SLICE.
- SLICE, 8, bits processed per cycle; internal slice uses borrow lookahead: g = ~a & b, p = ~(a ^ b).
- NS, WIDTH/SLICE (derived localparam, not overridable), number of slice cycles.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand request.
- in_ready  output  1  block can accept operands.
- A  input  WIDTH  minuend.
- B  input  WIDTH  subtrahend.
- Bin  input  1  borrow-in.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts result.
- Diff  output  WIDTH  A - B - Bin, modulo 2^WIDTH.
- Bout  output  1  final borrow; 1 iff unsigned A < B + Bin.
- Ovf  output  1  signed overflow: (A[msb] != B[msb]) && (Diff[msb] != A[msb]).
- Zero  output  1  Diff == 0.

Behaviour:
- Reset (rst=1 at a rising edge):
  - State goes to IDLE; in_ready=1, out_valid=0.
  - Diff=0, Bout=0, Ovf=0, Zero=0.
  - Slice counter and borrow register cleared.
  - Any in-flight operation is discarded, with no out_valid for it.
  - rst takes priority over every other event in the same cycle.
- State machine, IDLE / RUN / DONE:
  - IDLE: in_ready=1. On in_valid && in_ready, latch A, B and Bin into internal registers, clear the slice counter, and go to RUN. Otherwise stay in IDLE.
  - RUN: in_ready=0, out_valid=0. Each edge k (k = 0..NS-1) does three things:
    - computes slice k from the latched A, B and the borrow register;
    - writes Diff[k*SLICE +: SLICE];
    - registers that slice's borrow-out.
  - RUN exit: after the edge for k = NS-1, go to DONE, with Bout, Ovf and Zero registered on that same edge.
  - DONE: out_valid=1, in_ready=0. On out_ready=1, go to IDLE (in_ready=1 in the following cycle).
- Latency: out_valid rises exactly NS rising edges after the accepting edge; NS=4 for the defaults.
- Throughput: one operation per NS+2 cycles minimum. There is no acceptance in the same cycle as the output handshake.
- Operand inputs A, B and Bin are sampled only on the accepting edge; later changes have no effect on the result.
- While out_valid=1:
  - Diff, Bout, Ovf and Zero are stable until the handshake completes.
  - They retain their values after the handshake until the next RUN overwrites them.
  - Outputs are not checked outside out_valid.
- out_ready is ignored when out_valid=0. in_valid is ignored when in_ready=0.
- Borrow chain: the borrow into slice 0 is the latched Bin; the borrow into slice k>0 is the registered borrow-out of slice k-1.
- NS=1 configuration (WIDTH==SLICE) is legal: the result arrives one edge after acceptance.
- All arithmetic is unsigned modulo 2^WIDTH; Ovf gives the two's-complement interpretation.

Test Plan:
- Basic case: WIDTH=32, A=0x00000005, B=0x00000003, Bin=0.
  - Diff=0x00000002, Bout=0, Ovf=0, Zero=0.
  - out_valid high exactly 4 edges after acceptance.
- Full borrow ripple: A=0x00000000, B=0x00000001, Bin=0.
  - Diff=0xFFFFFFFF, Bout=1, Ovf=0, Zero=0.
  - Borrow propagates through all 4 slices.
- Signed overflow with borrow-in: A=0x80000000, B=0x00000000, Bin=1.
  - Diff=0x7FFFFFFF, Ovf=1, Bout=0.
- Zero result: A=0x12345678, B=0x12345677, Bin=1.
  - Diff=0x00000000, Zero=1, Bout=0, Ovf=0.
- Backpressure: hold out_ready=0 for 5 cycles in DONE, with in_valid=1 and new operands presented.
  - out_valid, Diff and flags stay stable; in_ready=0.
  - New operands are accepted only in the cycle after out_ready is raised, and produce their correct result.
- Reset mid-operation: assert rst for one cycle while in RUN at slice k=2.
  - Next cycle: out_valid=0, in_ready=1, Diff=0; no result is emitted for the aborted op.
  - The following operation A=0x00000100, B=0x00000001 yields Diff=0x000000FF, Bout=0.

Source files
------------

// File: rtl/seq_borrow_sub.sv
// Sequential WIDTH-bit subtractor: Diff = A - B - Bin, one SLICE-bit borrow-lookahead slice per clock, LSB first.
// Latency: out_valid rises NS rising edges after the accepting edge; one operation in flight (NS+2 cycles/op).
// Backpressure: result and flags hold in DONE until out_ready; in_ready is low from acceptance to handshake.
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   in_valid/in_ready   operand handshake; A, B, Bin sampled only on the accepting edge
//   out_valid/out_ready result handshake; Diff, Bout (unsigned borrow), Ovf (signed overflow), Zero
module seq_borrow_sub #(
   parameter int WIDTH = 32,
   parameter int SLICE = 8    // WIDTH must be an integer multiple of SLICE
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Bin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] Diff,
   output logic             Bout,
   output logic             Ovf,
   output logic             Zero
);

   localparam int NS = WIDTH / SLICE;
   localparam int CW = (NS > 1) ? $clog2(NS) : 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [WIDTH-1:0]  a_q, a_d;
   logic [WIDTH-1:0]  b_q, b_d;
   logic              brw_q, brw_d;     // borrow into the slice processed next
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [WIDTH-1:0]  diff_q, diff_d;
   logic              bout_q, bout_d;
   logic              ovf_q, ovf_d;
   logic              zero_q, zero_d;

   // Current slice operands and lookahead terms
   logic [SLICE-1:0]  sa, sb, sg, sp, sd;
   logic              s_bout;
   logic              bw;

   always_comb begin
      sa = '0;
      sb = '0;
      for (int k = 0; k < NS; k++) begin
         if (cnt_q == CW'(k)) begin
            sa = a_q[k*SLICE +: SLICE];
            sb = b_q[k*SLICE +: SLICE];
         end
      end
   end

   // Borrow generate: a=0,b=1 always borrows; propagate: a==b passes the incoming borrow through.
   assign sg = ~sa & sb;
   assign sp = ~(sa ^ sb);

   always_comb begin
      bw = brw_q;
      sd = '0;
      for (int i = 0; i < SLICE; i++) begin
         sd[i] = sa[i] ^ sb[i] ^ bw;
         bw    = sg[i] | (sp[i] & bw);
      end
      s_bout = bw;
   end

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      brw_d   = brw_q;
      cnt_d   = cnt_q;
      diff_d  = diff_q;
      bout_d  = bout_q;
      ovf_d   = ovf_q;
      zero_d  = zero_q;

      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               a_d     = A;
               b_d     = B;
               brw_d   = Bin;
               cnt_d   = '0;
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            for (int k = 0; k < NS; k++) begin
               if (cnt_q == CW'(k)) begin
                  diff_d[k*SLICE +: SLICE] = sd;
               end
            end
            brw_d = s_bout;
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(NS - 1)) begin
               // Flags use the fully assembled result including the slice written on this edge.
               bout_d  = s_bout;
               ovf_d   = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (diff_d[WIDTH-1] != a_q[WIDTH-1]);
               zero_d  = (diff_d == '0);
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            if (out_ready) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         brw_q   <= 1'b0;
         cnt_q   <= '0;
         diff_q  <= '0;
         bout_q  <= 1'b0;
         ovf_q   <= 1'b0;
         zero_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         brw_q   <= brw_d;
         cnt_q   <= cnt_d;
         diff_q  <= diff_d;
         bout_q  <= bout_d;
         ovf_q   <= ovf_d;
         zero_q  <= zero_d;
      end
   end

   assign in_ready  = (state_q == S_IDLE);
   assign out_valid = (state_q == S_DONE);
   assign Diff      = diff_q;
   assign Bout      = bout_q;
   assign Ovf       = ovf_q;
   assign Zero      = zero_q;

endmodule

// File: tb/tb_seq_borrow_sub.sv
// Testbench for seq_borrow_sub (WIDTH=32, SLICE=8, NS=4).
// Inputs change and outputs are sampled on the falling edge; the DUT acts on rising edges.
// Expected results come from a behavioural subtract model pushed to a scoreboard queue on acceptance.
module tb_seq_borrow_sub;

   localparam int W  = 32;
   localparam int NS = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  A;
   logic [W-1:0]  B;
   logic          Bin;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  Diff;
   logic          Bout;
   logic          Ovf;
   logic          Zero;

   seq_borrow_sub #(.WIDTH(W), .SLICE(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .A         (A),
      .B         (B),
      .Bin       (Bin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .Diff      (Diff),
      .Bout      (Bout),
      .Ovf       (Ovf),
      .Zero      (Zero)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [W-1:0] diff;
      logic         bout;
      logic         ovf;
      logic         zero;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;

   function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
      logic [W:0] r;
      exp_t       e;
      r      = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bin};
      e.diff = r[W-1:0];
      e.bout = r[W];
      e.ovf  = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
      e.zero = (r[W-1:0] == '0);
      return e;
   endfunction

   // Presents one operand set at a falling edge, waits (bounded) for acceptance,
   // pushes the model result, then scrambles the inputs to show they are not re-sampled.
   task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
      int n;
      n = 0;
      while (in_ready !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      total++;
      if (in_ready !== 1'b1) begin
         bad++;
         $display("FAIL send_wait_in_ready: in_ready=%b required=1", in_ready);
      end
      A        = a;
      B        = b;
      Bin      = bin;
      in_valid = 1'b1;
      sb.push_back(model(a, b, bin));
      @(negedge clk);
      in_valid = 1'b0;
      A        = $urandom;
      B        = $urandom;
      Bin      = 1'($urandom_range(0, 1));
   endtask

   task automatic test_reset;
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      A         = '0;
      B         = '0;
      Bin       = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      total++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         bad++;
         $display("FAIL reset_handshake: in_ready=%b out_valid=%b required 1/0", in_ready, out_valid);
      end
      total++;
      if (Diff !== '0) begin
         bad++;
         $display("FAIL reset_diff: got %h required 00000000", Diff);
      end
      total++;
      if ({Bout, Ovf, Zero} !== 3'b000) begin
         bad++;
         $display("FAIL reset_flags: bout/ovf/zero=%b required 000", {Bout, Ovf, Zero});
      end
   endtask

   task automatic test_basic;
      logic [W-1:0] ta[4];
      logic [W-1:0] tb[4];
      logic         tc[4];
      exp_t         e;
      int           lat;
      ta[0] = 32'h0000_0005; tb[0] = 32'h0000_0003; tc[0] = 1'b0;
      ta[1] = 32'h0000_0000; tb[1] = 32'h0000_0001; tc[1] = 1'b0;
      ta[2] = 32'h8000_0000; tb[2] = 32'h0000_0000; tc[2] = 1'b1;
      ta[3] = 32'h1234_5678; tb[3] = 32'h1234_5677; tc[3] = 1'b1;
      for (int i = 0; i < 4; i++) begin
         send(ta[i], tb[i], tc[i]);
         total++;
         if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL basic%0d_busy: in_ready=%b out_valid=%b required 0/0", i, in_ready, out_valid);
         end
         lat = 0;
         while (out_valid !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
         end
         total++;
         if (lat != NS) begin
            bad++;
            $display("FAIL basic%0d_latency: got %0d edges required %0d", i, lat, NS);
         end
         e = sb.pop_front();
         total++;
         if (Diff !== e.diff) begin
            bad++;
            $display("FAIL basic%0d_diff: got %h required %h", i, Diff, e.diff);
         end
         total++;
         if ({Bout, Ovf, Zero} !== {e.bout, e.ovf, e.zero}) begin
            bad++;
            $display("FAIL basic%0d_flags: bout/ovf/zero got %b required %b", i, {Bout, Ovf, Zero}, {e.bout, e.ovf, e.zero});
         end
         out_ready = 1'b1;
         @(negedge clk);
         out_ready = 1'b0;
         total++;
         if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL basic%0d_release: out_valid=%b in_ready=%b required 0/1", i, out_valid, in_ready);
         end
      end
   endtask

   task automatic test_backpressure;
      exp_t e;
      exp_t e2;
      int   lat;
      send(32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b1);
      lat = 0;
      while (out_valid !== 1'b1 && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      e = sb.pop_front();
      // New operands are offered throughout DONE and must be ignored.
      in_valid = 1'b1;
      A        = 32'h0000_1000;
      B        = 32'h0000_2000;
      Bin      = 1'b0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         total++;
         if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            bad++;
            $display("FAIL bp_hold%0d_handshake: out_valid=%b in_ready=%b required 1/0", c, out_valid, in_ready);
         end
         total++;
         if (Diff !== e.diff || {Bout, Ovf, Zero} !== {e.bout, e.ovf, e.zero}) begin
            bad++;
            $display("FAIL bp_hold%0d_result: got %h/%b required %h/%b", c, Diff, {Bout, Ovf, Zero}, e.diff, {e.bout, e.ovf, e.zero});
         end
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      total++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         bad++;
         $display("FAIL bp_no_accept_on_handshake: out_valid=%b in_ready=%b required 0/1", out_valid, in_ready);
      end
      sb.push_back(model(32'h0000_1000, 32'h0000_2000, 1'b0));
      @(negedge clk);
      in_valid = 1'b0;
      A        = $urandom;
      B        = $urandom;
      lat = 0;
      while (out_valid !== 1'b1 && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      total++;
      if (lat != NS) begin
         bad++;
         $display("FAIL bp_next_latency: got %0d edges required %0d", lat, NS);
      end
      e2 = sb.pop_front();
      total++;
      if (Diff !== e2.diff || {Bout, Ovf, Zero} !== {e2.bout, e2.ovf, e2.zero}) begin
         bad++;
         $display("FAIL bp_next_result: got %h/%b required %h/%b", Diff, {Bout, Ovf, Zero}, e2.diff, {e2.bout, e2.ovf, e2.zero});
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   task automatic test_reset_mid;
      exp_t e;
      int   lat;
      int   seen;
      send(32'h1111_2222, 32'h0101_0101, 1'b0);
      void'(sb.pop_back());
      // Two more rising edges process slices 0 and 1, leaving the counter at slice 2.
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      total++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         bad++;
         $display("FAIL midrst_handshake: out_valid=%b in_ready=%b required 0/1", out_valid, in_ready);
      end
      total++;
      if (Diff !== '0 || Bout !== 1'b0) begin
         bad++;
         $display("FAIL midrst_outputs: diff=%h bout=%b required 00000000/0", Diff, Bout);
      end
      seen = 0;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         if (out_valid === 1'b1) seen++;
      end
      total++;
      if (seen != 0) begin
         bad++;
         $display("FAIL midrst_no_result: out_valid high %0d cycles required 0", seen);
      end
      send(32'h0000_0100, 32'h0000_0001, 1'b0);
      lat = 0;
      while (out_valid !== 1'b1 && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      e = sb.pop_front();
      total++;
      if (lat != NS || Diff !== 32'h0000_00FF || Diff !== e.diff || Bout !== 1'b0) begin
         bad++;
         $display("FAIL midrst_next_op: lat=%0d diff=%h bout=%b required %0d/%h/0", lat, Diff, Bout, NS, e.diff);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   task automatic test_back_to_back;
      exp_t         e;
      int           lat;
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      for (int i = 0; i < 24; i++) begin
         ra = $urandom;
         rb = $urandom;
         if (i % 6 == 0) ra = rb;
         if (i % 6 == 1) ra = 32'h7FFF_FFFF;
         if (i % 6 == 2) rb = 32'hFFFF_FFFF;
         send(ra, rb, 1'($urandom_range(0, 1)));
         lat = 0;
         while (out_valid !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
         end
         e = sb.pop_front();
         total++;
         if (lat != NS || Diff !== e.diff || {Bout, Ovf, Zero} !== {e.bout, e.ovf, e.zero}) begin
            bad++;
            $display("FAIL b2b%0d: lat=%0d got %h/%b required %0d/%h/%b", i, lat, Diff, {Bout, Ovf, Zero}, NS, e.diff, {e.bout, e.ovf, e.zero});
         end
         out_ready = 1'b1;
         @(negedge clk);
         out_ready = 1'b0;
      end
      total++;
      if (sb.size() != 0) begin
         bad++;
         $display("FAIL scoreboard_drain: %0d entries left required 0", sb.size());
      end
   endtask

   initial begin
      test_reset;
      test_basic;
      test_backpressure;
      test_reset_mid;
      test_back_to_back;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

endmodule
